// File: rtl/mem_wait_ctrl_if.sv
// mem_wait_ctrl_if: MEM-stage request/response bundle between the pipeline and
// the multi-cycle data memory. The pipeline side is the master, the memory is
// the slave.
interface mem_wait_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] mem_result;
    logic              ready;
    logic              freeze;
    logic              out_of_range;
    logic              busy;

    modport master (
        output mem_r_en, mem_w_en, address, data_in,
        input  mem_result, ready, freeze, out_of_range, busy
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, data_in,
        output mem_result, ready, freeze, out_of_range, busy
    );
endinterface

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: multi-cycle data memory for the MEM stage. Each access holds
// the pipeline through freeze for WAIT_CYCLES cycles and finishes with a single
// ready pulse. Optional macro MEM_READ_BYPASS_EN adds a last-write register so
// a read that hits the most recently written word completes in one cycle.
module mem_wait_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input logic           clk,
    input logic           rst,
    mem_wait_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WINDOW   = ADDR_W'(4 * DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam bit SINGLE_CYCLE = (WAIT_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic [ADDR_W-1:0] in_off;
    logic              in_range;
    logic [IDX_W-1:0]  in_idx;
    logic [ADDR_W-1:0] q_off;
    logic              q_range;
    logic [IDX_W-1:0]  q_idx;
    logic              bypass_hit;
    logic              enter_done;
    logic              c_write;
    logic              c_range;
    logic [IDX_W-1:0]  c_idx;
    logic [DATA_W-1:0] c_data;
    logic [DATA_W-1:0] read_data;

`ifdef MEM_READ_BYPASS_EN
    logic              lw_valid;
    logic [IDX_W-1:0]  lw_idx;
    logic [DATA_W-1:0] lw_data;
`endif

    // Decode the live request and the captured one, and pick which of them is
    // the access finishing on the coming edge (live only for a one-cycle path).
    always_comb begin
        req      = bus.mem_r_en | bus.mem_w_en;
        in_off   = bus.address - BASE;
        in_range = (bus.address >= BASE) && (in_off < WINDOW);
        in_idx   = in_off[IDX_W+1:2];
        q_off    = addr_q - BASE;
        q_range  = (addr_q >= BASE) && (q_off < WINDOW);
        q_idx    = q_off[IDX_W+1:2];

        bypass_hit = 1'b0;
`ifdef MEM_READ_BYPASS_EN
        bypass_hit = (state == IDLE) && bus.mem_r_en && !bus.mem_w_en &&
                     in_range && lw_valid && (lw_idx == in_idx);
`endif

        enter_done = ((state == IDLE) && req && (SINGLE_CYCLE || bypass_hit)) ||
                     ((state == BUSY) && (cnt == CNT_W'(1)));

        if (state == IDLE) begin
            c_write = bus.mem_w_en;
            c_range = in_range;
            c_idx   = in_idx;
            c_data  = bus.data_in;
        end else begin
            c_write = write_q;
            c_range = q_range;
            c_idx   = q_idx;
            c_data  = data_q;
        end

        read_data = c_range ? mem[c_idx] : '0;
`ifdef MEM_READ_BYPASS_EN
        if (bypass_hit) begin
            read_data = lw_data;
        end
`endif
    end

    // Stall the pipeline from the first request cycle until DONE; reset drops it at once.
    assign bus.freeze = !rst && (((state == IDLE) && req) || (state == BUSY));

    // Access sequencer: capture, count wait states, then present the result for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            write_q          <= 1'b0;
            addr_q           <= '0;
            data_q           <= '0;
            bus.mem_result   <= '0;
            bus.ready        <= 1'b0;
            bus.out_of_range <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.ready        <= enter_done;
            bus.out_of_range <= enter_done && !c_range;
            if (enter_done && !c_write) begin
                bus.mem_result <= read_data;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        write_q  <= bus.mem_w_en;
                        addr_q   <= bus.address;
                        data_q   <= bus.data_in;
                        cnt      <= CNT_LOAD;
                        bus.busy <= 1'b1;
                        state    <= (SINGLE_CYCLE || bypass_hit) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Storage array: cleared during reset, written on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enter_done && c_write && c_range) begin
            mem[c_idx] <= c_data;
        end
    end

`ifdef MEM_READ_BYPASS_EN
    // Remember the most recent committed write so a matching read can skip the wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            lw_valid <= 1'b0;
            lw_idx   <= '0;
            lw_data  <= '0;
        end else if (enter_done && c_write && c_range) begin
            lw_valid <= 1'b1;
            lw_idx   <= c_idx;
            lw_data  <= c_data;
        end
    end
`endif
endmodule
